queens_search_ctrl: RTL and testbench

- Backtracking controller for the N-queens search; sequences the combinational queen-safety checker.
- Owns the board register and a per-row column stack; drives candidate (row, column, board) to the checker and samples its safe flag.
- Presents each solution with a valid/next handshake, counts solutions, and signals completion.

---
 rtl/queens_search_ctrl.sv | 155 +++++++++++++++
 tb/tb_queens_search_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/queens_search_ctrl.sv
// queens_search_ctrl: backtracking sequencer for the N-queens search.
// Owns the board and a per-row column stack. It presents candidates to an
// external combinational safety checker and hands each solution out with a
// valid/next handshake.
// Optional build macro: QUEENS_PERF_CNT_EN adds the cycle_cnt output.
module queens_search_ctrl #(
    parameter int N = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        next,
    output logic [2:0]  chk_row,
    output logic [2:0]  chk_clm,
    output logic [63:0] chk_board,
    input  logic        chk_safe,
    output logic        busy,
    output logic        sol_valid,
    output logic [23:0] sol_cols,
    output logic [7:0]  sol_count,
    output logic        done
`ifdef QUEENS_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PLACE,
        S_CHECK,
        S_BACKTRACK,
        S_FOUND,
        S_DONE
    } state_t;

    localparam logic [2:0] LAST = 3'(N - 1);

    state_t          state;
    logic [2:0]      row;
    logic [2:0]      col;
    logic [63:0]     board;
    logic [7:0][2:0] stack;
    logic [2:0]      prev_row;
    logic [2:0]      prev_col;

    assign chk_row   = row;
    assign chk_clm   = col;
    assign chk_board = board;
    assign sol_cols  = stack;

    // Row above the current one and the column its queen occupies.
    always_comb begin
        prev_row = row - 3'd1;
        prev_col = stack[prev_row];
    end

    // Search FSM: board/stack updates and registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            row       <= '0;
            col       <= '0;
            board     <= '0;
            stack     <= '0;
            sol_count <= '0;
            busy      <= 1'b0;
            sol_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        board     <= '0;
                        row       <= '0;
                        col       <= '0;
                        sol_count <= '0;
                        done      <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_PLACE;
                    end
                end
                S_PLACE: begin
                    board[{row, col}] <= 1'b1;
                    stack[row]        <= col;
                    state             <= S_CHECK;
                end
                S_CHECK: begin
                    if (chk_safe) begin
                        if (row == LAST) begin
                            sol_valid <= 1'b1;
                            if (sol_count != 8'hFF)
                                sol_count <= sol_count + 8'd1;
                            state <= S_FOUND;
                        end else begin
                            row   <= row + 3'd1;
                            col   <= '0;
                            state <= S_PLACE;
                        end
                    end else begin
                        board[{row, col}] <= 1'b0;
                        if (col != LAST) begin
                            col   <= col + 3'd1;
                            state <= S_PLACE;
                        end else begin
                            state <= S_BACKTRACK;
                        end
                    end
                end
                S_FOUND: begin
                    // Releasing a solution continues exactly as an unsafe last row.
                    if (next) begin
                        sol_valid         <= 1'b0;
                        board[{row, col}] <= 1'b0;
                        if (col != LAST) begin
                            col   <= col + 3'd1;
                            state <= S_PLACE;
                        end else begin
                            state <= S_BACKTRACK;
                        end
                    end
                end
                S_BACKTRACK: begin
                    if (row == 3'd0) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        row                         <= prev_row;
                        board[{prev_row, prev_col}] <= 1'b0;
                        if (prev_col != LAST) begin
                            col   <= prev_col + 3'd1;
                            state <= S_PLACE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef QUEENS_PERF_CNT_EN
    // Busy-cycle counter; FOUND cycles (waiting on the consumer) are excluded.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
        end else if ((state == S_IDLE || state == S_DONE) && start) begin
            cycle_cnt <= '0;
        end else if (state == S_PLACE || state == S_CHECK || state == S_BACKTRACK) begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_queens_search_ctrl.sv
// Testbench for queens_search_ctrl: four instances (N = 8, 4, 3, 1), each
// with a board-based behavioural safety checker, compared against a
// backtracking reference model of the search order and cycle cost.
module tb_queens_search_ctrl;

    localparam int NI = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a [NI];
    logic        next_a  [NI];
    logic [2:0]  row_a   [NI];
    logic [2:0]  clm_a   [NI];
    logic [63:0] board_a [NI];
    logic        safe_a  [NI];
    logic        busy_a  [NI];
    logic        valid_a [NI];
    logic [23:0] cols_a  [NI];
    logic [7:0]  cnt_a   [NI];
    logic        done_a  [NI];
`ifdef QUEENS_PERF_CNT_EN
    logic [31:0] cyc_a   [NI];
`endif
    logic        force_unsafe;

    int n_checks = 0;
    int n_fail   = 0;

    logic [23:0] exp_sols[$];
    int          exp_cyc;

    always #5 clk = ~clk;

    // A queen at (row, col) is safe if no earlier row attacks it.
    function automatic logic board_safe(input logic [63:0] b, input logic [2:0] row, input logic [2:0] col);
        int dr;
        int dc;
        for (int r = 0; r < 8; r++) begin
            if (r < int'(row)) begin
                for (int m = 0; m < 8; m++) begin
                    if (b[8*r+m]) begin
                        dr = int'(row) - r;
                        dc = m - int'(col);
                        if (dc == 0 || dc == dr || dc == -dr) return 1'b0;
                    end
                end
            end
        end
        return 1'b1;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        assign safe_a[g] = force_unsafe ? 1'b0 : board_safe(board_a[g], row_a[g], clm_a[g]);
        queens_search_ctrl #(.N(g == 0 ? 8 : g == 1 ? 4 : g == 2 ? 3 : 1)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .start     (start_a[g]),
            .next      (next_a[g]),
            .chk_row   (row_a[g]),
            .chk_clm   (clm_a[g]),
            .chk_board (board_a[g]),
            .chk_safe  (safe_a[g]),
            .busy      (busy_a[g]),
            .sol_valid (valid_a[g]),
            .sol_cols  (cols_a[g]),
            .sol_count (cnt_a[g]),
            .done      (done_a[g])
`ifdef QUEENS_PERF_CNT_EN
            ,
            .cycle_cnt (cyc_a[g])
`endif
        );
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] pk(input int c0, c1, c2, c3, c4, c5, c6, c7);
        return {3'(c7), 3'(c6), 3'(c5), 3'(c4), 3'(c3), 3'(c2), 3'(c1), 3'(c0)};
    endfunction

    // Reference search: lexicographic backtracking over column positions.
    // Produces the ordered solution list and the predicted non-FOUND busy
    // cycles (2 per candidate tried, 1 per backtrack step).
    task automatic model(input int n, input bit unsafe_all);
        int pos [8];
        int r, c, cand, bts;
        bit fin, ok;
        logic [23:0] s;
        exp_sols.delete();
        for (int i = 0; i < 8; i++) pos[i] = 0;
        r = 0; c = 0; cand = 0; bts = 0; fin = 0;
        while (!fin) begin
            cand++;
            ok = !unsafe_all;
            for (int k = 0; k < r; k++)
                if (pos[k] == c || pos[k] - c == r - k || c - pos[k] == r - k) ok = 0;
            if (ok) begin
                pos[r] = c;
                if (r == n - 1) begin
                    s = '0;
                    for (int k = 0; k < n; k++) s = s | (24'(pos[k]) << (3 * k));
                    exp_sols.push_back(s);
                end else begin
                    r++;
                    c = 0;
                    continue;
                end
            end
            if (c < n - 1) begin
                c++;
                continue;
            end
            forever begin
                bts++;
                if (r == 0) begin
                    fin = 1;
                    break;
                end
                r--;
                if (pos[r] < n - 1) begin
                    c = pos[r] + 1;
                    break;
                end
            end
        end
        exp_cyc = 2 * cand + bts;
    endtask

    // Start a search on instance g and follow it; stop_after>0 returns while
    // the stop_after-th solution is held, otherwise runs to done.
    task automatic run_search(input int g, input int n, input int stop_after, input bit hold_test,
                              input bit start_poke, input int nref, input logic [23:0] ref0,
                              input logic [23:0] ref1);
        int idx, cyc, budget, d, poke_at;
        logic [63:0] b0;
        logic [23:0] c0;
        logic [7:0]  k0;
        idx = 0; cyc = 0; budget = 0;
        model(n, force_unsafe);
        poke_at = int'($urandom_range(20, 2000));
        @(negedge clk);
        start_a[g] = 1'b1;
        @(negedge clk);
        while (budget < 60000) begin
            start_a[g] = 1'b0;
            next_a[g]  = 1'b0;
            if (done_a[g]) break;
            if (busy_a[g] && !valid_a[g]) cyc++;
            if (start_poke && cyc == poke_at) start_a[g] = 1'b1;
            if (valid_a[g]) begin
                if (idx < exp_sols.size()) check("sol_cols", 64'(cols_a[g]), 64'(exp_sols[idx]));
                else check("extra_sol", 64'(idx), 64'(exp_sols.size()));
                check("sol_count", 64'(cnt_a[g]), 64'((idx + 1 > 255) ? 255 : idx + 1));
                if (nref > 0 && idx == 0) check("first_sol", 64'(cols_a[g]), 64'(ref0));
                if (nref > 1 && idx == 1) check("second_sol", 64'(cols_a[g]), 64'(ref1));
                idx++;
                if (idx == stop_after) return;
                d  = (hold_test && idx == 1) ? 20 : int'($urandom_range(0, 3));
                b0 = board_a[g];
                c0 = cols_a[g];
                k0 = cnt_a[g];
                if (start_poke && idx == 3) start_a[g] = 1'b1;
                repeat (d) begin
                    @(negedge clk);
                    start_a[g] = 1'b0;
                    check("hold_valid", 64'(valid_a[g]), 64'd1);
                    check("hold_board", board_a[g], b0);
                    check("hold_cols", 64'(cols_a[g]), 64'(c0));
                    check("hold_count", 64'(cnt_a[g]), 64'(k0));
                end
                next_a[g] = 1'b1;
            end
            @(negedge clk);
            budget++;
        end
        start_a[g] = 1'b0;
        next_a[g]  = 1'b0;
        if (stop_after == 0) begin
            check("done", 64'(done_a[g]), 64'd1);
            check("busy_end", 64'(busy_a[g]), 64'd0);
            check("valid_end", 64'(valid_a[g]), 64'd0);
            check("sol_events", 64'(idx), 64'(exp_sols.size()));
            check("final_count", 64'(cnt_a[g]), 64'((exp_sols.size() > 255) ? 255 : exp_sols.size()));
            check("busy_cycles", 64'(cyc), 64'(exp_cyc));
`ifdef QUEENS_PERF_CNT_EN
            check("cycle_cnt", 64'(cyc_a[g]), 64'(exp_cyc));
`endif
        end
    endtask

    task automatic check_idle(input int g, input string tag);
        check({tag, "_busy"}, 64'(busy_a[g]), 64'd0);
        check({tag, "_valid"}, 64'(valid_a[g]), 64'd0);
        check({tag, "_done"}, 64'(done_a[g]), 64'd0);
        check({tag, "_count"}, 64'(cnt_a[g]), 64'd0);
        check({tag, "_board"}, board_a[g], 64'd0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        force_unsafe = 1'b0;
        for (int i = 0; i < NI; i++) begin
            start_a[i] = 1'b0;
            next_a[i]  = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NI; i++) check_idle(i, "reset");

        // Full N=8 run: long hold on the first solution, stray start pulses.
        run_search(0, 8, 0, 1'b1, 1'b1, 1, pk(0, 4, 7, 5, 2, 6, 1, 3), '0);
        // N=4 twice (second start from DONE), N=3 (no solutions), N=1.
        run_search(1, 4, 0, 1'b0, 1'b0, 2, pk(1, 3, 0, 2, 0, 0, 0, 0), pk(2, 0, 3, 1, 0, 0, 0, 0));
        run_search(1, 4, 0, 1'b0, 1'b0, 0, '0, '0);
        run_search(2, 3, 0, 1'b0, 1'b0, 0, '0, '0);
        run_search(3, 1, 0, 1'b0, 1'b0, 1, pk(0, 0, 0, 0, 0, 0, 0, 0), '0);

        // Reset while the 5th solution is held, then restart.
        run_search(0, 8, 5, 1'b0, 1'b0, 0, '0, '0);
        pulse_reset();
        check_idle(0, "midreset");
        run_search(0, 8, 1, 1'b0, 1'b0, 1, pk(0, 4, 7, 5, 2, 6, 1, 3), '0);
        pulse_reset();
        check_idle(0, "reset2");

        // Checker stuck unsafe: one row of candidates then a single backtrack.
        force_unsafe = 1'b1;
        run_search(0, 8, 0, 1'b0, 1'b0, 0, '0, '0);
        force_unsafe = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
